// File: rtl/shiftreg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// a small helper used by the frame counter.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // True for either shift direction; both advance the same frame counter.
    function automatic logic is_shift(input mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/shiftreg_cell.sv
// One bit of the universal shift register: a 4:1 next-state select (hold,
// left neighbour, right neighbour, parallel bit) feeding one flop with an
// asynchronous active-low reset.
module shiftreg_cell
    import shiftreg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_mode,
    input  logic       i_from_left,   // bit i+1 (or sin_r at the MSB), taken on shift right
    input  logic       i_from_right,  // bit i-1 (or sin_l at the LSB), taken on shift left
    input  logic       i_pdin,
    output logic       o_q
);

    logic  r_q;
    logic  w_next;
    mode_e w_mode;

    assign w_mode = mode_e'(i_mode);

    // Select the value this bit takes on the next edge.
    always_comb begin
        // NOTE: default assigned first so every path drives w_next and no latch is inferred.
        w_next = r_q;
        if (i_en) begin
            case (w_mode)
                MODE_HOLD: w_next = r_q;
                MODE_SHR:  w_next = i_from_left;
                MODE_SHL:  w_next = i_from_right;
                MODE_LOAD: w_next = i_pdin;
            endcase
        end
    end

    // Storage flop; clears immediately when rst falls.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignment so every cell samples its neighbours' old values.
        if (!rst) r_q <= 1'b0;
        else      r_q <= w_next;
    end

    assign o_q = r_q;

endmodule

// File: rtl/shiftreg_univ.sv
// Parametrised universal shift register (hold / shift right / shift left /
// parallel load) with serial taps at both ends and a frame counter that
// pulses frame_done once every WIDTH shifts.
module shiftreg_univ
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             frame_done
);

    // Last count value of a frame; the wrap is an explicit compare so
    // non-power-of-two widths close their frame at WIDTH shifts.
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_left_src;
    logic [WIDTH-1:0] w_right_src;
    logic [CW-1:0]    r_cnt;
    logic             r_frame_done;
    mode_e            w_mode;
    logic             w_shift;
    logic             w_load;
    logic             w_wrap;

    // Neighbour vectors: on shift right bit i takes bit i+1 (sin_r at the MSB);
    // on shift left bit i takes bit i-1 (sin_l at the LSB).
    assign w_left_src  = {sin_r, w_q[WIDTH-1:1]};
    assign w_right_src = {w_q[WIDTH-2:0], sin_l};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shiftreg_cell u_cell (
            .clk          (clk),
            .rst          (rst),
            .i_en         (en),
            .i_mode       (mode),
            .i_from_left  (w_left_src[i]),
            .i_from_right (w_right_src[i]),
            .i_pdin       (pdin[i]),
            .o_q          (w_q[i])
        );
    end

    assign w_mode  = mode_e'(mode);
    assign w_shift = en && is_shift(w_mode);
    assign w_load  = en && (w_mode == MODE_LOAD);
    assign w_wrap  = (r_cnt == CNT_LAST);

    // Frame counter: shifts of either direction advance it, a load restarts
    // the frame, and frame_done is high only for the cycle after the closing shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_shift) begin
                if (w_wrap) begin
                    r_cnt        <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign q          = w_q;
    assign sout_r     = w_q[0];
    assign sout_l     = w_q[WIDTH-1];
    assign cnt        = r_cnt;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_shiftreg_univ.sv
// Self-checking bench for shiftreg_univ: an 8-bit instance driven by directed
// vectors and a 4-bit instance wired as the legacy delay line. Behavioural
// models of both are compared against the DUT outputs every cycle, and
// hand-computed literals pin the models at the interesting points.
module tb_shiftreg_univ;
    import shiftreg_pkg::*;

    logic clk;
    logic rst;

    // 8-bit instance
    logic       en8, sin_r8, sin_l8, sout_r8, sout_l8, fd8;
    logic [1:0] mode8;
    logic [7:0] pdin8, q8;
    logic [2:0] cnt8;

    // 4-bit legacy delay line
    logic       din4, sout_r4, sout_l4, fd4;
    logic [3:0] q4;
    logic [1:0] cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    shiftreg_univ #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .mode(mode8), .sin_r(sin_r8), .sin_l(sin_l8),
        .pdin(pdin8), .q(q8), .sout_r(sout_r8), .sout_l(sout_l8), .cnt(cnt8), .frame_done(fd8)
    );

    shiftreg_univ #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(1'b1), .mode(2'b01), .sin_r(din4), .sin_l(1'b0),
        .pdin(4'h0), .q(q4), .sout_r(sout_r4), .sout_l(sout_l4), .cnt(cnt4), .frame_done(fd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model, 8-bit instance ----------------
    function automatic logic [7:0] next_q8(input logic [7:0] cur, input logic e,
                                           input logic [1:0] m, input logic sr,
                                           input logic sl, input logic [7:0] pd);
        int c;
        c = int'(cur);
        if (!e) return cur;
        case (m)
            2'b01:   return 8'((c / 2) + (sr ? 128 : 0));
            2'b10:   return 8'(((c * 2) % 256) + (sl ? 1 : 0));
            2'b11:   return pd;
            default: return cur;
        endcase
    endfunction

    logic [7:0] m_q;
    int         m_shifts;   // shifts since the last load/reset
    logic       m_fd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q      <= 8'h00;
            m_shifts <= 0;
            m_fd     <= 1'b0;
        end else begin
            m_q <= next_q8(m_q, en8, mode8, sin_r8, sin_l8, pdin8);
            if (en8 && mode8 == 2'b11) begin
                m_shifts <= 0;
                m_fd     <= 1'b0;
            end else if (en8 && (mode8 == 2'b01 || mode8 == 2'b10)) begin
                m_shifts <= m_shifts + 1;
                m_fd     <= ((m_shifts + 1) % 8 == 0);
            end else begin
                m_fd <= 1'b0;
            end
        end
    end

    // ---------------- behavioural model, legacy line ----------------
    // Record every bit presented at an edge; the register then holds the last
    // four recorded bits, newest at the MSB.
    logic din_at [0:4095];
    int   n4;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            n4 <= 0;
        end else begin
            if (n4 < 4096) din_at[n4] <= din4;
            n4 <= n4 + 1;
        end
    end

    function automatic logic exp4_bit(input int pos);
        int idx;
        idx = n4 - 4 + pos;
        return (idx >= 0) ? din_at[idx] : 1'b0;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        check("cyc q8",      q8,      m_q);
        check("cyc sout_r8", sout_r8, m_q % 2);
        check("cyc sout_l8", sout_l8, m_q / 128);
        check("cyc cnt8",    cnt8,    m_shifts % 8);
        check("cyc fd8",     fd8,     m_fd);
        check("cyc q4",      q4,      {exp4_bit(3), exp4_bit(2), exp4_bit(1), exp4_bit(0)});
        check("cyc sout_r4", sout_r4, exp4_bit(0));
        check("cyc sout_l4", sout_l4, exp4_bit(3));
        check("cyc cnt4",    cnt4,    n4 % 4);
        check("cyc fd4",     fd4,     (n4 > 0) && (n4 % 4 == 0));
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive8(input logic e, input logic [1:0] m, input logic sr,
                          input logic sl, input logic [7:0] pd);
        @(negedge clk);
        en8 = e; mode8 = m; sin_r8 = sr; sin_l8 = sl; pdin8 = pd;
    endtask

    task automatic idle8();
        drive8(1'b0, MODE_HOLD, 1'b0, 1'b0, 8'h00);
    endtask

    logic piso_exp   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic sipo_in    [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic legacy_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int pulses;
        rst = 1'b1; en8 = 1'b0; mode8 = MODE_HOLD; sin_r8 = 1'b0; sin_l8 = 1'b0;
        pdin8 = 8'h00; din4 = 1'b0;

        // Reset: outputs cleared asynchronously and held while rst is low.
        #1 rst = 1'b0;
        #2;
        check("reset q8",   q8,   8'h00);
        check("reset cnt8", cnt8, 3'd0);
        check("reset fd8",  fd8,  1'b0);
        check("reset q4",   q4,   4'h0);
        en8 = 1'b1; mode8 = MODE_LOAD; pdin8 = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset held q8", q8, 8'h00);
        rst = 1'b1; en8 = 1'b0; mode8 = MODE_HOLD; pdin8 = 8'h00;

        // Legacy delay line: 1,0,1,1 reappears on dout four cycles later.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din4 = legacy_pat[i];
        end
        @(negedge clk);
        check("legacy q4",  q4, 4'b1101);
        check("legacy dout0", sout_r4, 1'b1);
        din4 = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("legacy dout", sout_r4, legacy_pat[i]);
        end
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (fd4) pulses++;
        end
        check("legacy pulses/12cyc", pulses, 3);

        // Async reset mid-cycle with a loaded register and a non-zero count.
        drive8(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hFF);
        drive8(1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
        drive8(1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
        idle8();
        check("pre-reset q8",   q8,   8'hFF);
        check("pre-reset cnt8", cnt8, 3'd2);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async q8",   q8,   8'h00);
        check("async cnt8", cnt8, 3'd0);
        check("async fd8",  fd8,  1'b0);
        @(negedge clk);
        rst = 1'b1;

        // PISO: load 0xA5 and shift it out on sout_r.
        drive8(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("piso sout_r", sout_r8, piso_exp[i]);
            en8 = 1'b1; mode8 = MODE_SHR; sin_r8 = 1'b0; sin_l8 = 1'b0; pdin8 = 8'h00;
        end
        idle8();
        check("piso q8",   q8,   8'h00);
        check("piso cnt8", cnt8, 3'd0);
        check("piso fd8",  fd8,  1'b1);
        idle8();
        check("piso fd8 one cycle", fd8, 1'b0);

        // SIPO: shift 1,1,0,0,1,0,1,1 in from sin_l.
        for (int i = 0; i < 8; i++) begin
            drive8(1'b1, MODE_SHL, 1'b0, sipo_in[i], 8'h00);
            if (i == 7) check("sipo cnt8 before last", cnt8, 3'd7);
        end
        idle8();
        check("sipo q8",   q8,   8'hCB);
        check("sipo cnt8", cnt8, 3'd0);
        check("sipo fd8",  fd8,  1'b1);

        // Stall mid-frame, then finish the frame in the other direction.
        repeat (3) drive8(1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
        repeat (5) begin
            idle8();
            check("stall cnt8", cnt8, 3'd3);
            check("stall q8",   q8,   8'hF9);
            check("stall fd8",  fd8,  1'b0);
        end
        repeat (5) begin
            drive8(1'b1, MODE_SHL, 1'b0, 1'b0, 8'h00);
            check("stall resume fd8", fd8, 1'b0);
        end
        idle8();
        check("stall end q8",   q8,   8'h20);
        check("stall end cnt8", cnt8, 3'd0);
        check("stall end fd8",  fd8,  1'b1);

        // Load mid-frame restarts the frame.
        repeat (5) drive8(1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00);
        drive8(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h3C);
        drive8(1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00);
        check("load q8",   q8,   8'h3C);
        check("load cnt8", cnt8, 3'd0);
        check("load fd8",  fd8,  1'b0);
        repeat (3) drive8(1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00);
        idle8();
        check("load+4 q8",   q8,   8'h03);
        check("load+4 cnt8", cnt8, 3'd4);
        check("load+4 fd8",  fd8,  1'b0);
        repeat (4) drive8(1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
        idle8();
        check("load+8 q8",   q8,   8'hF0);
        check("load+8 cnt8", cnt8, 3'd0);
        check("load+8 fd8",  fd8,  1'b1);

        // Hold mode and disabled load leave everything untouched.
        repeat (3) drive8(1'b1, MODE_HOLD, 1'b1, 1'b1, 8'h55);
        drive8(1'b0, MODE_LOAD, 1'b0, 1'b0, 8'hAA);
        idle8();
        check("hold q8",   q8,   8'hF0);
        check("hold cnt8", cnt8, 3'd0);
        check("hold fd8",  fd8,  1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
